// File: rtl/uart_bram_cmd.sv
// UART command engine: host byte protocol for single-word writes and burst reads
// of an internal synchronous block RAM, with error responses and inter-byte timeout.
module uart_bram_cmd #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_we,
  input  logic       tx_busy,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam int AB = (ADDR_W + 7) / 8;
  localparam int NB = DATA_W / 8;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, CNT, DATA, WR, RD_REQ, RD_WAIT, SEND, TXGAP
  } state_t;

  state_t              state_q;
  logic                rd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_sh_q;
  logic [3:0]          bcnt_q;
  logic [3:0]          bleft_q;
  logic [8:0]          words_q;
  logic [TW-1:0]       tmo_q;
  logic [7:0]          err_q;
  logic [7:0]          tx_data_q;
  logic                tx_we_q;
  logic [DATA_W-1:0]   ram_rd_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Single-byte responses are loaded into the top byte of the word shifter.
  function automatic logic [DATA_W-1:0] resp_word(input logic [7:0] b);
    return DATA_W'(b) << (DATA_W - 8);
  endfunction

  always_ff @(posedge clk) begin
    if (state_q == WR) mem[addr_q] <= data_sh_q;
    ram_rd_q <= mem[addr_q];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      tx_we_q   <= 1'b0;
      tx_data_q <= 8'h00;
      err_q     <= 8'h00;
      bcnt_q    <= 4'd0;
      tmo_q     <= '0;
    end else begin
      tx_we_q <= 1'b0;
      case (state_q)
        IDLE: if (rx_valid) begin
          if (rx_data == 8'h57 || rx_data == 8'h52) begin
            rd_q    <= (rx_data == 8'h52);
            bcnt_q  <= 4'd0;
            tmo_q   <= '0;
            state_q <= ADDR;
          end else begin
            data_sh_q <= resp_word(8'h3F);
            bleft_q   <= 4'd1;
            words_q   <= 9'd1;
            err_q     <= sat_inc(err_q);
            state_q   <= SEND;
          end
        end
        ADDR, CNT, DATA: begin
          // A byte arriving on the expiry cycle wins over the timeout.
          if (rx_valid) begin
            tmo_q <= '0;
            if (state_q == ADDR) begin
              addr_q <= ADDR_W'({addr_q, rx_data});
              if (bcnt_q == 4'(AB - 1)) begin
                bcnt_q  <= 4'd0;
                state_q <= rd_q ? CNT : DATA;
              end else begin
                bcnt_q <= bcnt_q + 4'd1;
              end
            end else if (state_q == CNT) begin
              words_q <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
              state_q <= RD_REQ;
            end else begin
              data_sh_q <= DATA_W'({data_sh_q, rx_data});
              if (bcnt_q == 4'(NB - 1)) begin
                bcnt_q  <= 4'd0;
                state_q <= WR;
              end else begin
                bcnt_q <= bcnt_q + 4'd1;
              end
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_q   <= sat_inc(err_q);
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        WR: begin
          data_sh_q <= resp_word(8'h4B);
          bleft_q   <= 4'd1;
          words_q   <= 9'd1;
          state_q   <= SEND;
        end
        RD_REQ:  state_q <= RD_WAIT;
        RD_WAIT: begin
          data_sh_q <= ram_rd_q;
          bleft_q   <= 4'(NB);
          state_q   <= SEND;
        end
        SEND: if (!tx_busy) begin
          tx_data_q <= data_sh_q[DATA_W-1 -: 8];
          tx_we_q   <= 1'b1;
          data_sh_q <= DATA_W'({data_sh_q, 8'h00});
          bleft_q   <= bleft_q - 4'd1;
          state_q   <= TXGAP;
        end
        TXGAP: begin
          if (bleft_q != 4'd0) begin
            state_q <= SEND;
          end else if (words_q > 9'd1) begin
            words_q <= words_q - 9'd1;
            addr_q  <= addr_q + 1'b1;
            state_q <= RD_REQ;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // No input buffering while a response is in progress.
      if (rx_valid && (state_q inside {WR, RD_REQ, RD_WAIT, SEND, TXGAP}))
        err_q <= sat_inc(err_q);
    end
  end

  assign tx_data = tx_data_q;
  assign tx_we   = tx_we_q;
  assign busy    = (state_q != IDLE);
  assign err_cnt = err_q;

endmodule

// File: tb/tb_uart_bram_cmd.sv
// Directed bench for uart_bram_cmd: models the UART transmitter's busy handshake
// and compares every transmitted byte against hand-computed responses.
module tb_uart_bram_cmd;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_busy;
  logic       busy;
  logic [7:0] err_cnt;

  uart_bram_cmd #(.ADDR_W(12), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_we    (tx_we),
    .tx_busy  (tx_busy),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy from the cycle after a byte is accepted, for 6 cycles.
  logic [7:0] txq [$];
  int         tx_cnt = 0;
  int         viol   = 0;
  always @(posedge clk) begin
    if (tx_we && tx_busy) viol <= viol + 1;
    if (tx_we) begin
      txq.push_back(tx_data);
      tx_cnt <= 6;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
    end
  end
  assign tx_busy = (tx_cnt != 0);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic exp_tx(input string tag, input logic [7:0] b);
    logic [31:0] got;
    if (txq.size() > 0) got = {24'h0, txq.pop_front()};
    else got = 32'hFFFF_FFFF;
    check(tag, got, {24'h0, b});
  endtask

  task automatic wr_word(input logic [7:0] a1, input logic [7:0] a0,
                         input logic [7:0] d1, input logic [7:0] d0);
    send_byte(8'h57); send_byte(a1); send_byte(a0); send_byte(d1); send_byte(d0);
    wait_idle("wr_idle", 200);
    exp_tx("wr_ack", 8'h4B);
  endtask

  task automatic rd_cmd(input logic [7:0] a1, input logic [7:0] a0, input logic [7:0] n);
    send_byte(8'h52); send_byte(a1); send_byte(a0); send_byte(n);
  endtask

  initial begin
    resetn   = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_we", {31'h0, tx_we}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_err", {24'h0, err_cnt}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Write then read back.
    wr_word(8'h01, 8'h23, 8'hBE, 8'hEF);
    rd_cmd(8'h01, 8'h23, 8'h01);
    wait_idle("rd1_idle", 500);
    exp_tx("rd1_b0", 8'hBE);
    exp_tx("rd1_b1", 8'hEF);
    check("rd1_empty", txq.size(), 0);
    check("rd1_err", {24'h0, err_cnt}, 32'h0);

    // Burst wrapping from the top address to zero.
    wr_word(8'h0F, 8'hFF, 8'h11, 8'h11);
    wr_word(8'h00, 8'h00, 8'h22, 8'h22);
    rd_cmd(8'h0F, 8'hFF, 8'h02);
    wait_idle("wrap_idle", 500);
    exp_tx("wrap_b0", 8'h11);
    exp_tx("wrap_b1", 8'h11);
    exp_tx("wrap_b2", 8'h22);
    exp_tx("wrap_b3", 8'h22);
    check("wrap_empty", txq.size(), 0);

    // Upper address bits ignored; N=0 means 256 words.
    wr_word(8'hF1, 8'h23, 8'hA5, 8'h5A);
    rd_cmd(8'h01, 8'h23, 8'h00);
    wait_idle("n0_idle", 10000);
    check("n0_len", txq.size(), 512);
    exp_tx("n0_b0", 8'hA5);
    exp_tx("n0_b1", 8'h5A);
    txq.delete();
    check("no_we_while_busy", viol, 0);

    // Bad opcode.
    send_byte(8'h41);
    wait_idle("bad_idle", 200);
    exp_tx("bad_resp", 8'h3F);
    check("bad_err", {24'h0, err_cnt}, 32'h1);

    // Overrun during a 4-word burst.
    for (int a = 0; a < 4; a++) wr_word(8'h03, 8'(a), 8'hC3, 8'(a));
    check("pre_ovr_err", {24'h0, err_cnt}, 32'h1);
    rd_cmd(8'h03, 8'h00, 8'h04);
    for (int i = 0; i < 500 && txq.size() < 2; i++) @(negedge clk);
    send_byte(8'h52);
    wait_idle("ovr_idle", 1000);
    for (int a = 0; a < 4; a++) begin
      exp_tx("ovr_hi", 8'hC3);
      exp_tx("ovr_lo", 8'(a));
    end
    check("ovr_empty", txq.size(), 0);
    check("ovr_err", {24'h0, err_cnt}, 32'h2);

    // Inter-byte timeout.
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_still_busy", {31'h0, busy}, 32'h1);
    repeat (2) @(negedge clk);
    check("tmo_busy", {31'h0, busy}, 32'h0);
    check("tmo_no_tx", txq.size(), 0);
    check("tmo_err", {24'h0, err_cnt}, 32'h3);
    rd_cmd(8'h01, 8'h23, 8'h01);
    wait_idle("tmo_rd_idle", 500);
    exp_tx("tmo_rd_b0", 8'hA5);
    exp_tx("tmo_rd_b1", 8'h5A);
    check("tmo_rd_err", {24'h0, err_cnt}, 32'h3);

    // Reset in the middle of a burst.
    rd_cmd(8'h03, 8'h00, 8'h04);
    for (int i = 0; i < 500 && txq.size() < 3; i++) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (100) @(negedge clk);
    check("mid_rst_txcount", txq.size(), 3);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_err", {24'h0, err_cnt}, 32'h0);
    check("mid_rst_tx_data", {24'h0, tx_data}, 32'h0);
    txq.delete();
    rd_cmd(8'h03, 8'h00, 8'h01);
    wait_idle("post_rst_idle", 500);
    exp_tx("post_rst_b0", 8'hC3);
    exp_tx("post_rst_b1", 8'h00);
    check("final_viol", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_bram_cmd.md
Name: uart_bram_cmd

Overview:
UART command engine that gives a host byte-level read/write access to an internal block RAM.
- Sits between the uart_rx byte output (data/valid) and the uart_tx byte input (data/data_we/data_wait-style busy).
- Successor to the fixed 8-bit x 4096 echo memory: width, depth and timeout are parametrised.
- Adds addressed single-word writes, burst reads with auto-increment, error responses and an inter-byte timeout.

Parameters:
ADDR_W, 12, RAM address width; depth = 2**ADDR_W words.
DATA_W, 16, word width in bits; must be a multiple of 8, range 8..64.
TIMEOUT, 100000, max clk cycles allowed between bytes of one command.
- Derived, not settable: AB = ceil(ADDR_W/8) address bytes per command; NB = DATA_W/8 bytes per word.

Ports:
clk  in  1  clock.
resetn  in  1  synchronous, active-low reset.
rx_data  in  8  received byte; valid only while rx_valid=1.
rx_valid  in  1  one-cycle strobe, one byte per strobe.
tx_data  out  8  byte to transmit; held stable from the tx_we cycle until the next tx_we.
tx_we  out  1  one-cycle transmit strobe.
tx_busy  in  1  transmitter shifting; high from the cycle after accepting a byte until that byte is done.
busy  out  1  high whenever the FSM is not in IDLE.
err_cnt  out  8  saturating count of protocol errors.

Behaviour:
Reset (resetn=0 at a clk edge):
- FSM goes to IDLE; tx_we=0, tx_data=0x00, busy=0, err_cnt=0.
- RAM contents are not cleared.
- Reset has priority over every event, including mid-command and mid-burst; the partial command is discarded and no further bytes are sent.

Command format: all multi-byte fields are MSB first.
- WRITE: 0x57, AB address bytes, NB data bytes.
- READ: 0x52, AB address bytes, 1 count byte N. N=0 means 256 words.
- Address bits above ADDR_W are ignored.

FSM states: IDLE, ADDR, CNT, DATA, WR, RD_REQ, RD_WAIT, SEND, TXGAP.
- IDLE, on rx_valid:
  - 0x57 or 0x52: latch the opcode, go to ADDR.
  - Any other byte: queue response 0x3F, increment err_cnt, go to SEND.
- ADDR: shift in AB bytes. Then go to DATA (write) or CNT (read).
- CNT: latch N, go to RD_REQ.
- DATA: shift in NB bytes, then go to WR.
- WR: one cycle; write the RAM word, queue response 0x4B, go to SEND.
- RD_REQ: present the address to the RAM. The RAM has synchronous read with 1-cycle latency.
- RD_WAIT: capture the word into the shift register, go to SEND.
- SEND: when tx_busy=0, drive tx_data and pulse tx_we, then go to TXGAP.
- TXGAP: one cycle in which tx_busy is not sampled (covers the transmitter's 1-cycle busy latency), then:
  - more bytes of the current word: back to SEND;
  - word done and words remain: address+1, wrapping 2**ADDR_W-1 to 0; go to RD_REQ;
  - otherwise: IDLE.

Response byte counts:
- Write ack: exactly 1 byte.
- Read: N*NB bytes. No opcode echo, no terminator.

Timeout:
- In ADDR/CNT/DATA, a counter reloads on each rx_valid.
- When TIMEOUT cycles elapse with no byte: discard the command, increment err_cnt, return to IDLE. No response is sent.

RX during response: rx_valid in WR, RD_*, SEND or TXGAP drops the byte and increments err_cnt. No buffering.

Simultaneous events: a timeout expiring in the same cycle as rx_valid is resolved in favour of the byte (accept it, no error).

err_cnt saturates at 0xFF.

Read-after-write: a read issued immediately after a write's ack returns the new data.

Test Plan:
- Write then read: send 57 01 23 BE EF, then 52 01 23 01 -> tx 4B, then BE EF; err_cnt=0.
- Burst wrap: write 0xFFF=0x1111 and 0x000=0x2222, then 52 0F FF 02 -> tx 11 11 22 22.
- Address masking and N=0: write 0x0123=0xA55A via address bytes F1 23. Then 52 01 23 00 -> 512 bytes, first two A5 5A. Check tx_we pulses never occur while tx_busy=1.
- Bad opcode and overrun: send 0x41 -> tx 3F, err_cnt=1. During a 4-word burst, inject one rx byte -> burst completes unchanged, err_cnt=2.
- Timeout: send 57 01 and then nothing for TIMEOUT+1 cycles -> no tx, busy falls, err_cnt +1. The next 52 01 23 01 works normally.
- Reset mid-burst: resetn=0 for 1 cycle after the 3rd response byte -> tx_we stays 0, busy=0, err_cnt=0. RAM data survives (re-read returns the same value).
